// File: rtl/set_bit_serializer_if.sv
// Handshake bundle for set_bit_serializer: request side (data_i/data_val_i/
// data_ready_o) and beat side (onehot_o/index_o/last_o/data_val_o/ready_i).
// The slave modport is the serializer's view; master is the environment's view.
interface set_bit_serializer_if #(
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] data_i;
  logic             data_val_i;
  logic             data_ready_o;
  logic [WIDTH-1:0] onehot_o;
  logic [IDX_W-1:0] index_o;
  logic             last_o;
  logic             data_val_o;
  logic             ready_i;

  modport slave (
    input  data_i, data_val_i, ready_i,
    output data_ready_o, onehot_o, index_o, last_o, data_val_o
  );

  modport master (
    output data_i, data_val_i, ready_i,
    input  data_ready_o, onehot_o, index_o, last_o, data_val_o
  );
endinterface

// File: rtl/set_bit_serializer.sv
// set_bit_serializer: accepts a WIDTH-bit request word and emits its set bits
// one per beat as a one-hot word plus binary index, flagging the final beat.
// An all-zero word still produces one beat (onehot 0, index 0, last 1).
// Optional feature: define SET_BIT_SERIALIZER_MSB_FIRST_EN to emit the
// highest set bit first; the default build emits the lowest set bit first.
module set_bit_serializer #(
  parameter int WIDTH = 16
) (
  input logic                clk_i,
  input logic                srst_i,
  set_bit_serializer_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;

  // Pick the bit that goes out next from a word of pending bits.
  function automatic word_t isolate(input word_t x);
`ifdef SET_BIT_SERIALIZER_MSB_FIRST_EN
    word_t r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
`else
    return x & (~x + word_t'(1));
`endif
  endfunction

  // Binary position of a one-hot word; 0 for an all-zero word.
  function automatic logic [IDX_W-1:0] index_of(input word_t oh);
    logic [IDX_W-1:0] r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  word_t            rem_q, rem_d;
  word_t            onehot_q, onehot_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             last_q, last_d;
  logic             val_q, val_d;

  logic  slot_free;
  logic  rem_empty;
  logic  data_ready;
  logic  in_xfer;
  word_t src;
  word_t iso;
  word_t nxt;

  // Handshake qualifiers; ready is combinational from ready_i so the next word
  // can enter in the same cycle the previous word's last beat leaves.
  always_comb begin
    slot_free  = !val_q || bus.ready_i;
    rem_empty  = (rem_q == '0);
    data_ready = !srst_i && rem_empty && slot_free;
    in_xfer    = bus.data_val_i && data_ready;
    src        = rem_empty ? bus.data_i : rem_q;
    iso        = isolate(src);
    nxt        = src & ~iso;
  end

  // Beat slot load: drain pending bits first, otherwise take a new word.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    rem_d    = rem_q;
    onehot_d = onehot_q;
    index_d  = index_q;
    last_d   = last_q;
    val_d    = val_q;
    if (slot_free) begin
      if (!rem_empty || in_xfer) begin
        onehot_d = iso;
        index_d  = index_of(iso);
        last_d   = (nxt == '0);
        rem_d    = nxt;
        val_d    = 1'b1;
      end else begin
        val_d    = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; reset drops any pending beat and bits.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (srst_i) begin
      rem_q    <= '0;
      onehot_q <= '0;
      index_q  <= '0;
      last_q   <= 1'b0;
      val_q    <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      onehot_q <= onehot_d;
      index_q  <= index_d;
      last_q   <= last_d;
      val_q    <= val_d;
    end
  end

  // Drive the interface from the beat registers.
  always_comb begin
    bus.data_ready_o = data_ready;
    bus.onehot_o     = onehot_q;
    bus.index_o      = index_q;
    bus.last_o       = last_q;
    bus.data_val_o   = val_q;
  end
endmodule

// File: tb/tb_set_bit_serializer.sv
// Self-checking bench for set_bit_serializer (WIDTH=16). A queue model expands
// each accepted word into its expected beats; a negedge process checks the DUT
// against it every cycle, and literal beat lists pin the model per scenario.
module tb_set_bit_serializer;
  localparam int WIDTH = 16;

  logic clk_i = 1'b0;
  logic srst_i;

  set_bit_serializer_if #(.WIDTH(WIDTH)) sbus ();

  set_bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .bus    (sbus)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt = 0;
  int model_q[$];
  int seen[$];
  int exp_q[$];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Beat packed as {last, index[3:0], onehot[15:0]}.
  function automatic int pack(input int oh, input int idx, input int last);
    return (last << 20) | (idx << 16) | (oh & 32'hFFFF);
  endfunction

  // Expected beats of one word, straight from the ordering rule.
  task automatic push_word(input logic [15:0] w);
    int bits[$];
    if (w == 16'h0) begin
      model_q.push_back(pack(0, 0, 1));
      return;
    end
`ifdef SET_BIT_SERIALIZER_MSB_FIRST_EN
    for (int i = WIDTH - 1; i >= 0; i--) if (w[i]) bits.push_back(i);
`else
    for (int i = 0; i < WIDTH; i++) if (w[i]) bits.push_back(i);
`endif
    foreach (bits[k])
      model_q.push_back(pack(1 << bits[k], bits[k], (k == bits.size() - 1) ? 1 : 0));
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk_i) begin
    int dut_beat;
    bit exp_val;
    if (srst_i) begin
      check("ready_in_reset", int'(sbus.data_ready_o), 0);
      model_q.delete();
    end else begin
      exp_val  = (model_q.size() != 0);
      dut_beat = pack(int'(sbus.onehot_o), int'(sbus.index_o), int'(sbus.last_o));
      check("data_val_o", int'(sbus.data_val_o), int'(exp_val));
      if (exp_val) check("beat", dut_beat, model_q[0]);
      check("data_ready_o", int'(sbus.data_ready_o),
            int'(model_q.size() == 0 || (model_q.size() == 1 && sbus.ready_i)));
      if (sbus.data_val_o && !sbus.ready_i) stall_cnt++;
      if (sbus.data_val_o && sbus.ready_i) seen.push_back(dut_beat);
      if (exp_val && sbus.ready_i) void'(model_q.pop_front());
      if (sbus.data_val_i && sbus.data_ready_o) push_word(sbus.data_i);
    end
  end

  task automatic send(input logic [15:0] w);
    bit done = 1'b0;
    sbus.data_i     = w;
    sbus.data_val_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      if (sbus.data_ready_o) done = 1'b1;
      @(posedge clk_i);
      #1;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    sbus.data_val_i = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      if (model_q.size() == 0 && !sbus.data_val_o) done = 1'b1;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_seen(input string name);
    check({name, "_count"}, seen.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < seen.size()) check(name, seen[i], exp_q[i]);
    seen.delete();
  endtask

  task automatic check_cleared(input string name);
    check({name, "_val"},    int'(sbus.data_val_o), 0);
    check({name, "_onehot"}, int'(sbus.onehot_o), 0);
    check({name, "_index"},  int'(sbus.index_o), 0);
    check({name, "_last"},   int'(sbus.last_o), 0);
    check({name, "_ready"},  int'(sbus.data_ready_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst_i          = 1'b1;
    sbus.data_i     = '0;
    sbus.data_val_i = 1'b0;
    sbus.ready_i    = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 srst_i = 1'b0;
    @(negedge clk_i);
    check_cleared("post_reset");
    @(posedge clk_i);
    #1;

    // Multi-bit word.
    seen.delete();
    send(16'h8421);
    drain();
`ifdef SET_BIT_SERIALIZER_MSB_FIRST_EN
    exp_q = {32'h0F8000, 32'h0A0400, 32'h050020, 32'h100001};
`else
    exp_q = {32'h000001, 32'h050020, 32'h0A0400, 32'h1F8000};
`endif
    check_seen("w8421");

    // Empty word.
    send(16'h0000);
    drain();
    exp_q = {32'h100000};
    check_seen("empty");

    // Backpressure: stall the first beat for three cycles.
    stall_cnt = 0;
    send(16'h0006);
    sbus.data_val_i = 1'b0;
    sbus.ready_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 sbus.ready_i = 1'b1;
    drain();
    check("stall_cycles", stall_cnt, 3);
`ifdef SET_BIT_SERIALIZER_MSB_FIRST_EN
    exp_q = {32'h020004, 32'h110002};
`else
    exp_q = {32'h010002, 32'h120004};
`endif
    check_seen("backpressure");

    // Back-to-back words with no bubble.
    send(16'h0001);
    send(16'hC000);
    drain();
`ifdef SET_BIT_SERIALIZER_MSB_FIRST_EN
    exp_q = {32'h100001, 32'h0F8000, 32'h1E4000};
`else
    exp_q = {32'h100001, 32'h0E4000, 32'h1F8000};
`endif
    check_seen("b2b");

    // Reset mid-word after the first beat of 0xFFFF has transferred.
    send(16'hFFFF);
    sbus.data_val_i = 1'b0;
    @(posedge clk_i);
    #1 srst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 srst_i = 1'b0;
    @(negedge clk_i);
    check_cleared("mid_reset");
    @(posedge clk_i);
    #1;
    send(16'h0010);
    drain();
`ifdef SET_BIT_SERIALIZER_MSB_FIRST_EN
    exp_q = {32'h0F8000, 32'h140010};
`else
    exp_q = {32'h000001, 32'h140010};
`endif
    check_seen("mid_reset_seq");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
